mdio_controlador: RTL and testbench

- Management-side MDIO master: the stage directly upstream of the MDIO target (PHY-side) block.
- Generates a free-running `mdc` from the system clock.
- Serialises a 32-bit management frame onto `mdio_out`/`mdio_oe`, MSB first, no preamble.
- For read frames, releases the line after the 16-bit header and shifts in 16 data bits from `mdio_in`, then presents them on a parallel port with a strobe.

---
 rtl/mdio_controlador.sv | 175 +++++++++++++++++
 tb/tb_mdio_controlador.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_controlador.sv
// MDIO management master: divides clk into a free-running mdc and shifts one
// 32-bit frame out MSB first on mdc falls; read frames capture 16 bits on mdc rises.
//
// state | meaning
// IDLE  | line released; waits for a pending frame and the next mdc fall
// SEND  | write frame: driving all 32 bits
// HEAD  | read frame: driving the 16 header bits
// RECV  | read frame: line released, sampling 16 data bits on mdc rises
module mdio_controlador #(
    parameter int DIV = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mdio_start,
    input  logic [31:0] t_data,
    output logic        busy,
    output logic [15:0] data_out,
    output logic        data_rdy,
    output logic        mdc,
    output logic        mdio_oe,
    output logic        mdio_out,
    input  logic        mdio_in
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        HEAD = 2'd2,
        RECV = 2'd3
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] div_cnt;
    logic          mdc_q;
    logic          half_wrap, fall_ev, rise_ev;
    logic [31:0]   tx_sh, tx_sh_n;
    logic [15:0]   rx_sh, rx_sh_n;
    logic [4:0]    bit_cnt, bit_cnt_n;
    logic [4:0]    rx_cnt, rx_cnt_n;
    logic          pending, pending_n;
    logic          busy_q, busy_n;
    logic          oe_q, oe_n;
    logic          out_q, out_n;
    logic          rdy_q, rdy_n;
    logic [15:0]   dout_q, dout_n;
    logic          op_wr, op_rd;

    assign half_wrap = (div_cnt == DIV_LAST);
    assign fall_ev   = half_wrap & mdc_q;
    assign rise_ev   = half_wrap & ~mdc_q;

    // tx_sh is only unshifted while IDLE, which is the only place OP is decoded
    assign op_wr = (tx_sh[29:28] == 2'b01);
    assign op_rd = (tx_sh[29:28] == 2'b10);

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
            mdc_q   <= 1'b0;
        end else if (half_wrap) begin
            div_cnt <= '0;
            mdc_q   <= ~mdc_q;
        end else begin
            div_cnt <= div_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            tx_sh   <= '0;
            rx_sh   <= '0;
            bit_cnt <= '0;
            rx_cnt  <= '0;
            pending <= 1'b0;
            busy_q  <= 1'b0;
            oe_q    <= 1'b0;
            out_q   <= 1'b0;
            rdy_q   <= 1'b0;
            dout_q  <= '0;
        end else begin
            state   <= state_n;
            tx_sh   <= tx_sh_n;
            rx_sh   <= rx_sh_n;
            bit_cnt <= bit_cnt_n;
            rx_cnt  <= rx_cnt_n;
            pending <= pending_n;
            busy_q  <= busy_n;
            oe_q    <= oe_n;
            out_q   <= out_n;
            rdy_q   <= rdy_n;
            dout_q  <= dout_n;
        end
    end

    always_comb begin
        state_n   = state;
        tx_sh_n   = tx_sh;
        rx_sh_n   = rx_sh;
        bit_cnt_n = bit_cnt;
        rx_cnt_n  = rx_cnt;
        pending_n = pending;
        busy_n    = busy_q;
        oe_n      = oe_q;
        out_n     = out_q;
        rdy_n     = 1'b0;
        dout_n    = dout_q;

        if (mdio_start && !busy_q) begin
            tx_sh_n   = t_data;
            pending_n = 1'b1;
            busy_n    = 1'b1;
        end

        case (state)
            IDLE: begin
                if (pending) begin
                    if (!op_wr && !op_rd) begin
                        pending_n = 1'b0;
                        busy_n    = 1'b0;
                    end else if (fall_ev) begin
                        oe_n      = 1'b1;
                        out_n     = tx_sh[31];
                        bit_cnt_n = '0;
                        pending_n = 1'b0;
                        state_n   = op_wr ? SEND : HEAD;
                    end
                end
            end
            SEND, HEAD: begin
                if (fall_ev) begin
                    if (state == SEND && bit_cnt == 5'd31) begin
                        oe_n    = 1'b0;
                        out_n   = 1'b0;
                        busy_n  = 1'b0;
                        state_n = IDLE;
                    end else if (state == HEAD && bit_cnt == 5'd15) begin
                        oe_n     = 1'b0;
                        out_n    = 1'b0;
                        rx_cnt_n = '0;
                        state_n  = RECV;
                    end else begin
                        bit_cnt_n = bit_cnt + 5'd1;
                        tx_sh_n   = {tx_sh[30:0], 1'b0};
                        out_n     = tx_sh[30];
                    end
                end
            end
            RECV: begin
                // publish one cycle after the 16th capture edge
                if (rx_cnt == 5'd16) begin
                    dout_n  = rx_sh;
                    rdy_n   = 1'b1;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end else if (rise_ev) begin
                    rx_sh_n  = {rx_sh[14:0], mdio_in};
                    rx_cnt_n = rx_cnt + 5'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy     = busy_q;
    assign data_out = dout_q;
    assign data_rdy = rdy_q;
    assign mdc      = mdc_q;
    assign mdio_oe  = oe_q;
    assign mdio_out = out_q;

endmodule

// File: tb/tb_mdio_controlador.sv
// Bench for mdio_controlador: a timeline model of each frame (edge indices
// computed from the launch edge) checked every cycle, plus literal checks.
module tb_mdio_controlador;

    logic        clk;
    logic        reset, reset1;
    logic        mdio_start, mdio_start1;
    logic [31:0] t_data, t_data1;
    logic        busy, busy1;
    logic [15:0] data_out, data_out1;
    logic        data_rdy, data_rdy1;
    logic        mdc, mdc1;
    logic        mdio_oe, mdio_oe1;
    logic        mdio_out, mdio_out1;
    logic        mdio_in, mdio_in1;

    mdio_controlador #(.DIV(2)) dut (
        .clk(clk), .reset(reset), .mdio_start(mdio_start), .t_data(t_data),
        .busy(busy), .data_out(data_out), .data_rdy(data_rdy), .mdc(mdc),
        .mdio_oe(mdio_oe), .mdio_out(mdio_out), .mdio_in(mdio_in)
    );

    mdio_controlador #(.DIV(1)) dut1 (
        .clk(clk), .reset(reset1), .mdio_start(mdio_start1), .t_data(t_data1),
        .busy(busy1), .data_out(data_out1), .data_rdy(data_rdy1), .mdc(mdc1),
        .mdio_oe(mdio_oe1), .mdio_out(mdio_out1), .mdio_in(mdio_in1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // model state per instance: accept edge, frame, read value, data_out before frame
    int          cyc[2];
    int          m_a[2];
    logic [31:0] m_fr[2];
    logic [15:0] m_rd[2];
    logic [15:0] m_prev[2];
    logic [15:0] m_cur[2];

    // monitors
    logic [31:0] col0, col1;
    int          ncol0, ncol1, noe0, nrdy0, nbusy0;
    logic        pmdc0, pmdc1, poe1, pbusy1;
    int          l1, e1;

    // target (PHY) model for reads on instance 0
    logic        tgt_en, tgt_seen;
    logic [15:0] tgt_val;
    int          tgt_idx;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model(input int div, input int k, input int a,
                                  input logic [31:0] fr, input logic [15:0] rd,
                                  input logic [15:0] prev,
                                  output logic e_mdc, output logic e_oe, output logic e_out,
                                  output logic e_busy, output logic e_rdy,
                                  output logic [15:0] e_dout);
        int p, lf, cap, nbits;
        logic [1:0] op;
        p      = 2 * div;
        e_mdc  = ((k / div) % 2) == 1;
        e_oe   = 1'b0;
        e_out  = 1'b0;
        e_busy = 1'b0;
        e_rdy  = 1'b0;
        e_dout = prev;
        if (a >= 0 && k >= a) begin
            op = fr[29:28];
            if (op != 2'b01 && op != 2'b10) begin
                e_busy = (k == a);
            end else begin
                lf    = (a / p + 1) * p;
                nbits = (op == 2'b01) ? 32 : 16;
                if (k >= lf && k < lf + nbits * p) begin
                    e_oe  = 1'b1;
                    e_out = fr[31 - (k - lf) / p];
                end
                if (op == 2'b01) begin
                    e_busy = (k < lf + 32 * p);
                end else begin
                    cap    = lf + 31 * p + div;
                    e_busy = (k <= cap);
                    e_rdy  = (k == cap + 1);
                    if (k > cap) e_dout = rd;
                end
            end
        end
    endfunction

    task automatic step();
        logic r0, r1;
        logic e_mdc, e_oe, e_out, e_busy, e_rdy;
        logic [15:0] e_dout;
        r0 = reset;
        r1 = reset1;
        @(posedge clk);
        cyc[0] = r0 ? 0 : cyc[0] + 1;
        cyc[1] = r1 ? 0 : cyc[1] + 1;
        @(negedge clk);

        model(2, cyc[0], m_a[0], m_fr[0], m_rd[0], m_prev[0], e_mdc, e_oe, e_out, e_busy, e_rdy, e_dout);
        m_cur[0] = e_dout;
        chk("model_div2", {43'd0, mdc, mdio_oe, mdio_out, busy, data_rdy, data_out},
            {43'd0, e_mdc, e_oe, e_out, e_busy, e_rdy, e_dout});
        model(1, cyc[1], m_a[1], m_fr[1], m_rd[1], m_prev[1], e_mdc, e_oe, e_out, e_busy, e_rdy, e_dout);
        m_cur[1] = e_dout;
        chk("model_div1", {43'd0, mdc1, mdio_oe1, mdio_out1, busy1, data_rdy1, data_out1},
            {43'd0, e_mdc, e_oe, e_out, e_busy, e_rdy, e_dout});

        if (tgt_en) begin
            if (mdio_oe) begin
                tgt_seen = 1'b1;
                tgt_idx  = 0;
            end else if (tgt_seen && mdc && !pmdc0) begin
                tgt_idx++;
            end
            mdio_in = (tgt_seen && tgt_idx < 16) ? tgt_val[15 - tgt_idx] : 1'b0;
        end else begin
            tgt_seen = 1'b0;
            tgt_idx  = 0;
            mdio_in  = 1'b0;
        end

        if (mdc && !pmdc0 && mdio_oe) begin
            col0 = {col0[30:0], mdio_out};
            ncol0++;
        end
        if (mdio_oe) noe0++;
        if (data_rdy) nrdy0++;
        if (busy) nbusy0++;
        pmdc0 = mdc;

        if (mdc1 && !pmdc1 && mdio_oe1) begin
            col1 = {col1[30:0], mdio_out1};
            ncol1++;
        end
        if (mdio_oe1 && !poe1) l1 = cyc[1];
        if (!busy1 && pbusy1) e1 = cyc[1];
        pmdc1  = mdc1;
        poe1   = mdio_oe1;
        pbusy1 = busy1;
    endtask

    task automatic clear_mon();
        col0 = '0; ncol0 = 0; noe0 = 0; nrdy0 = 0; nbusy0 = 0;
        col1 = '0; ncol1 = 0; l1 = -1; e1 = -1;
    endtask

    task automatic start0(input logic [31:0] fr);
        t_data     = fr;
        mdio_start = 1'b1;
        m_prev[0]  = m_cur[0];
        m_a[0]     = cyc[0] + 1;
        m_fr[0]    = fr;
        step();
        mdio_start = 1'b0;
    endtask

    task automatic start1(input logic [31:0] fr);
        t_data1     = fr;
        mdio_start1 = 1'b1;
        m_prev[1]   = m_cur[1];
        m_a[1]      = cyc[1] + 1;
        m_fr[1]     = fr;
        step();
        mdio_start1 = 1'b0;
    endtask

    task automatic wait_idle0(input int max);
        int n;
        n = 0;
        while (busy && n < max) begin
            step();
            n++;
        end
        chk("idle_wait0", {63'd0, busy}, 64'd0);
    endtask

    task automatic wait_idle1(input int max);
        int n;
        n = 0;
        while (busy1 && n < max) begin
            step();
            n++;
        end
        chk("idle_wait1", {63'd0, busy1}, 64'd0);
    endtask

    initial begin
        reset = 1'b1; reset1 = 1'b1;
        mdio_start = 1'b0; mdio_start1 = 1'b0;
        t_data = '0; t_data1 = '0;
        mdio_in = 1'b0; mdio_in1 = 1'b0;
        tgt_en = 1'b0; tgt_seen = 1'b0; tgt_val = '0; tgt_idx = 0;
        pmdc0 = 1'b0; pmdc1 = 1'b0; poe1 = 1'b0; pbusy1 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cyc[i] = 0; m_a[i] = -1; m_fr[i] = '0; m_rd[i] = '0; m_prev[i] = '0; m_cur[i] = '0;
        end
        clear_mon();
        step();
        step();
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_dout", {48'd0, data_out}, 64'd0);
        chk("rst_mdc_oe", {62'd0, mdc, mdio_oe}, 64'd0);
        reset = 1'b0; reset1 = 1'b0;
        step();

        // plain write
        clear_mon();
        start0(32'h50A3BEEF);
        wait_idle0(400);
        step();
        chk("wr_stream", {32'd0, col0}, 64'h50A3BEEF);
        chk("wr_nbits", ncol0, 64'd32);
        chk("wr_oe_cycles", noe0, 64'd128);
        chk("wr_no_rdy", nrdy0, 64'd0);
        chk("wr_dout", {48'd0, data_out}, 64'd0);

        // read with target returning 0xA5C3
        clear_mon();
        tgt_val = 16'hA5C3; m_rd[0] = 16'hA5C3; tgt_en = 1'b1;
        start0(32'h60A20000);
        wait_idle0(400);
        step();
        step();
        tgt_en = 1'b0;
        chk("rd_header", {48'd0, col0[15:0]}, 64'h60A2);
        chk("rd_nbits", ncol0, 64'd16);
        chk("rd_oe_cycles", noe0, 64'd64);
        chk("rd_dout", {48'd0, data_out}, 64'hA5C3);
        chk("rd_one_rdy", nrdy0, 64'd1);

        // second start during a write is dropped
        clear_mon();
        start0(32'h5A5A1234);
        for (int i = 0; i < 20; i++) step();
        t_data = 32'h6FFF0000; mdio_start = 1'b1;
        step();
        mdio_start = 1'b0; t_data = '0;
        wait_idle0(400);
        for (int i = 0; i < 12; i++) step();
        chk("ign_stream", {32'd0, col0}, 64'h5A5A1234);
        chk("ign_nbits", ncol0, 64'd32);
        chk("ign_dout", {48'd0, data_out}, 64'hA5C3);

        // reset during bit 10 of a read, then a clean write
        clear_mon();
        tgt_en = 1'b1;
        start0(32'h60A20000);
        for (int i = 0; i < 200 && noe0 < 42; i++) step();
        chk("mid_reached", {63'd0, noe0 >= 42}, 64'd1);
        reset = 1'b1; m_a[0] = -1; m_prev[0] = '0; m_cur[0] = '0;
        step();
        chk("mid_rst_oe_busy_mdc", {61'd0, mdio_oe, busy, mdc}, 64'd0);
        chk("mid_rst_dout", {48'd0, data_out}, 64'd0);
        reset = 1'b0; tgt_en = 1'b0;
        step();
        clear_mon();
        start0(32'h5123ABCD);
        wait_idle0(400);
        chk("post_rst_stream", {32'd0, col0}, 64'h5123ABCD);
        chk("post_rst_nbits", ncol0, 64'd32);

        // illegal OPs, then a back-to-back legal write
        clear_mon();
        start0(32'h40000000);
        step();
        chk("op00_busy", nbusy0, 64'd1);
        start0(32'h70000000);
        step();
        chk("op11_busy", nbusy0, 64'd2);
        chk("bad_op_no_oe", noe0, 64'd0);
        start0(32'h5F00C0DE);
        wait_idle0(400);
        chk("b2b_stream", {32'd0, col0}, 64'h5F00C0DE);

        // DIV=1 instance
        clear_mon();
        start1(32'h50A3BEEF);
        wait_idle1(200);
        step();
        chk("div1_stream", {32'd0, col1}, 64'h50A3BEEF);
        chk("div1_latency", e1 - l1, 64'd64);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
